// File: rtl/mic_store_pkg.sv
// ---------------------------------------------------------------------------
// mic_store_pkg
// Shared definitions for the microphone sample store:
//   DEPTH       - number of stored samples per capture
//   AW          - address width, log2(DEPTH)
//   DW          - sample width, signed two's complement
//   mic_state_e - capture controller states (IDLE, CAPTURE, FULL)
// ---------------------------------------------------------------------------
package mic_store_pkg;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 18;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2
    } mic_state_e;

endpackage : mic_store_pkg

// File: rtl/mic_sample_ram.sv
// ---------------------------------------------------------------------------
// mic_sample_ram
// DEPTH x DW sample storage with one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
// Ports:
//   clk       - write clock, rising edge
//   i_wr_en   - write enable
//   i_wr_addr - write address
//   i_wr_data - write data
//   i_rd_addr - read address
//   o_rd_data - read data, same-cycle
// ---------------------------------------------------------------------------
module mic_sample_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 18
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : mic_sample_ram

// File: rtl/mic_data_store.sv
// ---------------------------------------------------------------------------
// mic_data_store
// Captures DEPTH consecutive microphone samples after a start request and
// signals "buffer full" with a one-cycle pulse; stored samples can be read
// back combinationally at any time.
// Ports:
//   clk                  - clock, rising edge
//   rst_n                - asynchronous active-low reset
//   mic_1                - signed sample to capture
//   start                - capture-arm request, acts on its rising edge
//   finish_left_or_right - sample-valid strobe, acts on its rising edge
//   output_flag          - read enable; out_data is 0 while low
//   adb_cnt              - read address
//   out_data             - sample at adb_cnt (zero-latency read)
//   output_start_flag    - one-cycle pulse after the last sample is written
// Handshake: there is no back-pressure. A strobe edge seen in CAPTURE is a
// write that is always accepted; edges seen in IDLE or FULL are dropped.
// ---------------------------------------------------------------------------
module mic_data_store #(
    parameter int DEPTH = mic_store_pkg::DEPTH,
    parameter int AW    = mic_store_pkg::AW,
    parameter int DW    = mic_store_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] mic_1,
    input  logic          start,
    input  logic          finish_left_or_right,
    input  logic          output_flag,
    input  logic [AW-1:0] adb_cnt,
    output logic [DW-1:0] out_data,
    output logic          output_start_flag
);

    import mic_store_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    mic_state_e    r_state;
    mic_state_e    w_state_nxt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] w_wr_ptr_nxt;
    logic          r_start_d;
    logic          r_strobe_d;
    logic          r_full_pulse;
    logic          w_full_pulse_nxt;
    logic          w_wr_en;
    logic          w_start_edge;
    logic          w_strobe_edge;
    logic [DW-1:0] w_rd_data;

    // Rising-edge detectors: current level high, previous level low.
    assign w_start_edge  = start & ~r_start_d;
    assign w_strobe_edge = finish_left_or_right & ~r_strobe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_start_d    <= 1'b0;
            r_strobe_d   <= 1'b0;
            r_full_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_start_d    <= start;
            r_strobe_d   <= finish_left_or_right;
            r_full_pulse <= w_full_pulse_nxt;
        end
    end

    // Start edges only take effect outside CAPTURE, so a capture in
    // progress can't be restarted. A strobe edge coincident with the
    // arming start edge is not written because the state is still IDLE/FULL.
    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_wr_en          = 1'b0;
        w_full_pulse_nxt = 1'b0;
        case (r_state)
            IDLE, FULL: begin
                if (w_start_edge) begin
                    w_state_nxt  = CAPTURE;
                    w_wr_ptr_nxt = '0;
                end
            end
            CAPTURE: begin
                if (w_strobe_edge) begin
                    w_wr_en = 1'b1;
                    if (r_wr_ptr == LAST_ADDR) begin
                        // Last slot written: stop instead of wrapping.
                        w_state_nxt      = FULL;
                        w_wr_ptr_nxt     = '0;
                        w_full_pulse_nxt = 1'b1;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt  = IDLE;
                w_wr_ptr_nxt = '0;
            end
        endcase
    end

    mic_sample_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (mic_1),
        .i_rd_addr (adb_cnt),
        .o_rd_data (w_rd_data)
    );

    assign out_data          = output_flag ? w_rd_data : '0;
    assign output_start_flag = r_full_pulse;

endmodule : mic_data_store

// File: tb/tb_mic_data_store.sv
module tb_mic_data_store;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 18;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] mic_1;
    logic          start;
    logic          finish_left_or_right;
    logic          output_flag;
    logic [AW-1:0] adb_cnt;
    logic [DW-1:0] out_data;
    logic          output_start_flag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic rd_req = 1'b0;

    logic [DW-1:0] exp_q[$];
    int            pulse_q[$];

    mic_data_store #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .mic_1                (mic_1),
        .start                (start),
        .finish_left_or_right (finish_left_or_right),
        .output_flag          (output_flag),
        .adb_cnt              (adb_cnt),
        .out_data             (out_data),
        .output_start_flag    (output_start_flag)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (output_start_flag) begin
            checks++;
            if (pulse_q.size() == 0) begin
                errors++;
                $display("FAIL pulse: unexpected output_start_flag at cycle %0d, none expected", cyc);
            end else begin
                int exp_cyc;
                exp_cyc = pulse_q.pop_front();
                if (exp_cyc != cyc) begin
                    errors++;
                    $display("FAIL pulse: output_start_flag at cycle %0d, expected cycle %0d", cyc, exp_cyc);
                end
            end
        end
        if (rd_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read: no expected value queued, addr=%0d got=%h", adb_cnt, out_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL read: flag=%0b addr=%0d got=%h expected=%h",
                             output_flag, adb_cnt, out_data, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_edge();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic strobe_edge(input logic [DW-1:0] v, input int hold, input bit last);
        tick();
        mic_1 = v;
        finish_left_or_right = 1'b1;
        if (last) pulse_q.push_back(cyc + 1);
        repeat (hold) tick();
        finish_left_or_right = 1'b0;
    endtask

    task automatic do_read(input logic flag, input int addr, input logic [DW-1:0] e);
        tick();
        output_flag = flag;
        adb_cnt = AW'(addr);
        exp_q.push_back(e);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        output_flag = 1'b0;
    endtask

    task automatic check_idle_pulses(input string tag);
        repeat (3) tick();
        checks++;
        if (pulse_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulse(s) not seen, required 0 outstanding", tag, pulse_q.size());
        end
    endtask

    function automatic logic [DW-1:0] val(input int kind, input int i);
        case (kind)
            0:       val = DW'(i - 512);
            1:       val = DW'(i + 5000);
            2:       val = (i % 2 == 0) ? 18'h1FFFF : 18'h20000;
            default: val = DW'(3 * i - 1000);
        endcase
    endfunction

    // kind 0 adds a 5-cycle held strobe at index 100 and a start edge
    // before index 300; n < DEPTH leaves the capture unfinished.
    task automatic capture(input int kind, input int n);
        for (int i = 0; i < n; i++) begin
            if (kind == 0 && i == 300) start_edge();
            strobe_edge(val(kind, i), (kind == 0 && i == 100) ? 5 : 1, (i == DEPTH - 1));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        mic_1 = '0;
        start = 1'b0;
        finish_left_or_right = 1'b0;
        output_flag = 1'b0;
        adb_cnt = '0;
        #1;
        checks++;
        if (output_start_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulse: got=%b expected=0", output_start_flag);
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got=%h expected=0", out_data);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        do_read(1'b0, 17, '0);

        // Strobes before any start are dropped.
        for (int i = 0; i < 3; i++) strobe_edge(18'h15555, 1, 1'b0);
        check_idle_pulses("pre_start");

        // Capture 1: start edge coincident with a strobe edge (not written).
        tick();
        start = 1'b1;
        finish_left_or_right = 1'b1;
        mic_1 = 18'h00309;
        tick();
        start = 1'b0;
        finish_left_or_right = 1'b0;
        capture(0, DEPTH);
        check_idle_pulses("capture1");
        do_read(1'b1, 0,    18'h3FE00);   // -512
        do_read(1'b1, 511,  18'h3FFFF);   // -1
        do_read(1'b1, 1023, 18'h001FF);   // 511
        do_read(1'b1, 100,  DW'(-412));
        do_read(1'b1, 101,  DW'(-411));
        do_read(1'b1, 300,  DW'(-212));
        do_read(1'b0, 1023, '0);
        do_read(1'b0, 5,    '0);
        do_read(1'b1, 5,    DW'(-507));

        // Strobes in FULL are ignored.
        for (int i = 0; i < 4; i++) strobe_edge(18'h12345, 1, 1'b0);
        check_idle_pulses("full_strobes");
        for (int i = 0; i < 4; i++) do_read(1'b1, i, DW'(i - 512));

        // Capture aborted by reset at sample 700; old data visible beyond.
        start_edge();
        capture(1, 700);
        do_read(1'b1, 10,  DW'(5010));
        do_read(1'b1, 699, DW'(5699));
        do_read(1'b1, 800, DW'(288));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (output_start_flag !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: got=%b expected=0", output_start_flag);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) strobe_edge(18'h0F0F0, 1, 1'b0);
        check_idle_pulses("abort");
        do_read(1'b0, 10, '0);
        do_read(1'b1, 10, DW'(5010));

        // Capture 2: extreme values alternating.
        start_edge();
        capture(2, DEPTH);
        check_idle_pulses("capture2");
        do_read(1'b1, 0,    18'h1FFFF);
        do_read(1'b1, 1,    18'h20000);
        do_read(1'b1, 700,  18'h1FFFF);
        do_read(1'b1, 800,  18'h1FFFF);
        do_read(1'b1, 1023, 18'h20000);

        // Capture 3: restart from FULL, new data replaces everything.
        start_edge();
        capture(3, DEPTH);
        check_idle_pulses("capture3");
        do_read(1'b1, 0,    DW'(-1000));
        do_read(1'b1, 1,    DW'(-997));
        do_read(1'b1, 512,  DW'(536));
        do_read(1'b1, 1023, DW'(2069));

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d read expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mic_data_store

// File: doc/mic_data_store.md
MIC_DATA_STORE -- requirements
Module: mic_data_store

Interface
REQ-001 Parameter DEPTH, default 1024, number of stored samples.
REQ-002 Parameter AW, default 10, address width, equal to log2(DEPTH).
REQ-003 Parameter DW, default 18, sample width, signed two's complement.
REQ-004 Port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port mic_1, input, DW bits: signed sample to capture.
REQ-007 Port start, input, 1 bit: capture-arm request; acts on its rising edge.
REQ-008 Port finish_left_or_right, input, 1 bit: sample-valid strobe; acts on its rising edge.
REQ-009 Port output_flag, input, 1 bit: read-enable for out_data.
REQ-010 Port adb_cnt, input, AW bits: read address.
REQ-011 Port out_data, output, DW bits: signed sample read back.
REQ-012 Port output_start_flag, output, 1 bit: one-cycle "buffer full" pulse.

Function
REQ-013 Edge detection SHALL use one register each for start and finish_left_or_right; an edge is (current high AND registered copy low).
REQ-014 The FSM SHALL have three states: IDLE, CAPTURE and FULL.
REQ-015 A start edge in IDLE or FULL SHALL move to CAPTURE and clear the write pointer wr_ptr to 0.
REQ-016 A start edge in CAPTURE SHALL be ignored.
REQ-017 In CAPTURE, each finish_left_or_right edge SHALL write mic_1 (value in the same cycle) to mem[wr_ptr] and increment wr_ptr.
REQ-018 A strobe edge in the same cycle as the start edge that enters CAPTURE SHALL NOT be written.
REQ-019 Writing address DEPTH-1 SHALL move the FSM to FULL and assert output_start_flag for exactly the next single clock cycle.
REQ-020 Strobe edges in IDLE or FULL SHALL be ignored; memory contents are held.
REQ-021 out_data SHALL equal mem[adb_cnt] combinationally, with zero-cycle read latency, while output_flag = 1.
REQ-022 out_data SHALL be 0 while output_flag = 0.
REQ-023 Reads are permitted in any state; reads during CAPTURE return the old contents at addresses not yet overwritten.
REQ-024 wr_ptr SHALL never wrap within one capture; exactly DEPTH samples are stored per capture.
REQ-025 Sample data SHALL pass through unmodified: no scaling, no sign change.

Reset
REQ-026 Asserting rst_n low SHALL immediately force the FSM to IDLE and wr_ptr to 0.
REQ-027 Reset SHALL clear both edge-detect registers and set output_start_flag to 0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset during CAPTURE SHALL abort the capture with no output_start_flag pulse; a new start edge is then required.
REQ-030 After reset, out_data SHALL follow REQ-021 and REQ-022: 0 while output_flag = 0.

Structure
REQ-031 A shared package mic_store_pkg SHALL hold DEPTH, AW, DW and the state enum (IDLE, CAPTURE, FULL).
REQ-032 Storage SHALL be one sub-module, mic_sample_ram: DEPTH x DW, one synchronous write port, one asynchronous read port.
REQ-033 Control logic (FSM, edge detectors, wr_ptr, pulse) SHALL reside in mic_data_store.

Verification
REQ-034 Reset, start edge, then 1024 strobe edges with mic_1 = index-512 -> output_start_flag is high for one cycle after the 1024th edge; with output_flag=1, adb_cnt=0/511/1023 give out_data=-512/-1/511.
REQ-035 Strobe held high for 5 cycles, or 3 edges issued before any start -> at most one write per edge; no writes before start; pulse only after exactly 1024 edges.
REQ-036 Start edge mid-capture at sample 300 -> ignored; pulse still after the 1024th edge.
REQ-037 rst_n low at sample 700, then release -> no pulse; restart with mic_1 = 18'sh1FFFF (max positive) and 18'sh20000 (min negative) alternating -> values read back exactly after the pulse.
REQ-038 output_flag=0 with any adb_cnt -> out_data=0; toggle output_flag to 1 -> data appears in the same cycle.
REQ-039 Second start edge in FULL, then 1024 new samples -> second pulse; memory holds only the new data.
